// File: rtl/vga_rx_monitor.sv
// VGA stream monitor: measures hsync/vsync timing, locks after one clean frame and emits
// active-area pixel coordinates and colour. One pixel-edge latency; pix_en=0 holds everything.
module vga_rx_monitor #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter int SYNC_POL = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic       hs,
   input  logic       vs,
   input  logic [3:0] r,
   input  logic [3:0] g,
   input  logic [3:0] b,
   output logic       px_valid,
   output logic [9:0] px_x,
   output logic [9:0] px_y,
   output logic [3:0] px_r,
   output logic [3:0] px_g,
   output logic [3:0] px_b,
   output logic       frame_start,
   output logic       locked,
   output logic       err_hlen,
   output logic       err_hsync,
   output logic       err_vlen,
   output logic [7:0] err_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic        POL        = (SYNC_POL != 0);
   localparam logic [11:0] H_TOTAL_L  = 12'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_L  = 11'(V_TOTAL);
   localparam logic [10:0] H_SYNC_L   = 11'(H_SYNC);
   localparam logic [10:0] ACT_H_LO   = 11'(H_SYNC + H_BP);
   localparam logic [10:0] ACT_H_HI   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [9:0]  ACT_V_LO   = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  ACT_V_HI   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   state_t      state_q, state_d;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        hs_prev_q, hs_prev_d;
   logic        vs_line_q, vs_line_d;
   logic        h_seen_q, h_seen_d;
   logic        v_seen_q, v_seen_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic        px_valid_q, px_valid_d;
   logic [9:0]  px_x_q, px_x_d, px_y_q, px_y_d;
   logic [3:0]  px_r_q, px_r_d, px_g_q, px_g_d, px_b_q, px_b_d;
   logic        frame_start_q, frame_start_d;
   logic        err_hlen_q, err_hlen_d, err_hsync_q, err_hsync_d, err_vlen_q, err_vlen_d;

   logic        hs_a, vs_a, hs_lead, hs_trail, frame_b, any_err, active;
   logic [11:0] line_len;
   logic [10:0] frame_lines;

   always_comb begin
      hs_a        = (hs == POL);
      vs_a        = (vs == POL);
      hs_lead     = hs_a & ~hs_prev_q;
      hs_trail    = ~hs_a & hs_prev_q;
      frame_b     = hs_lead & vs_a & ~vs_line_q;
      line_len    = {1'b0, h_cnt_q} + 12'd1;
      frame_lines = {1'b0, v_cnt_q} + 11'd1;

      state_d   = state_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      vs_line_d = vs_line_q;
      hs_prev_d = hs_a;
      h_seen_d  = h_seen_q | hs_lead;
      v_seen_d  = v_seen_q | frame_b;

      if (hs_lead) begin
         h_cnt_d = '0;
      end else if (h_cnt_q != '1) begin
         h_cnt_d = h_cnt_q + 11'd1;
      end

      if (hs_lead) begin
         vs_line_d = vs_a;
         if (frame_b) begin
            v_cnt_d = '0;
         end else if (v_cnt_q != '1) begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end

      // Checks only report once a frame boundary has been seen (i.e. outside SEARCH).
      err_hlen_d    = (state_q != SEARCH) & hs_lead & h_seen_q & (line_len != H_TOTAL_L);
      err_hsync_d   = (state_q != SEARCH) & hs_trail & (h_cnt_d != H_SYNC_L);
      err_vlen_d    = (state_q != SEARCH) & frame_b & v_seen_q & (frame_lines != V_TOTAL_L);
      any_err       = err_hlen_d | err_hsync_d | err_vlen_d;
      frame_start_d = frame_b;

      err_cnt_d = err_cnt_q;
      if (any_err && err_cnt_q != 8'hFF) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      case (state_q)
         SEARCH:  if (frame_b) state_d = ALIGN;
         ALIGN:   if (any_err) state_d = SEARCH;
                  else if (frame_b) state_d = LOCKED;
         LOCKED:  if (any_err) state_d = SEARCH;
         default: state_d = SEARCH;
      endcase

      active = (h_cnt_d >= ACT_H_LO) && (h_cnt_d <= ACT_H_HI) &&
               (v_cnt_d >= ACT_V_LO) && (v_cnt_d <= ACT_V_HI);

      px_valid_d = active && (state_d == LOCKED);
      px_x_d     = '0;
      px_y_d     = '0;
      px_r_d     = '0;
      px_g_d     = '0;
      px_b_d     = '0;
      if (px_valid_d) begin
         px_x_d = 10'(h_cnt_d - ACT_H_LO);
         px_y_d = v_cnt_d - ACT_V_LO;
         px_r_d = r;
         px_g_d = g;
         px_b_d = b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SEARCH;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hs_prev_q     <= 1'b0;
         vs_line_q     <= 1'b0;
         h_seen_q      <= 1'b0;
         v_seen_q      <= 1'b0;
         err_cnt_q     <= '0;
         px_valid_q    <= 1'b0;
         px_x_q        <= '0;
         px_y_q        <= '0;
         px_r_q        <= '0;
         px_g_q        <= '0;
         px_b_q        <= '0;
         frame_start_q <= 1'b0;
         err_hlen_q    <= 1'b0;
         err_hsync_q   <= 1'b0;
         err_vlen_q    <= 1'b0;
      end else if (pix_en) begin
         state_q       <= state_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hs_prev_q     <= hs_prev_d;
         vs_line_q     <= vs_line_d;
         h_seen_q      <= h_seen_d;
         v_seen_q      <= v_seen_d;
         err_cnt_q     <= err_cnt_d;
         px_valid_q    <= px_valid_d;
         px_x_q        <= px_x_d;
         px_y_q        <= px_y_d;
         px_r_q        <= px_r_d;
         px_g_q        <= px_g_d;
         px_b_q        <= px_b_d;
         frame_start_q <= frame_start_d;
         err_hlen_q    <= err_hlen_d;
         err_hsync_q   <= err_hsync_d;
         err_vlen_q    <= err_vlen_d;
      end
   end

   assign px_valid    = px_valid_q;
   assign px_x        = px_x_q;
   assign px_y        = px_y_q;
   assign px_r        = px_r_q;
   assign px_g        = px_g_q;
   assign px_b        = px_b_q;
   assign frame_start = frame_start_q;
   assign locked      = (state_q == LOCKED);
   assign err_hlen    = err_hlen_q;
   assign err_hsync   = err_hsync_q;
   assign err_vlen    = err_vlen_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced 16x9 raster so whole frames stay short.
module tb_vga_rx_monitor;

   // Raster: hsync 3, bp 3, active 8, fp 2 -> 16; vsync 2, bp 2, active 4, fp 1 -> 9.
   // Active columns 6..13, active lines 4..7, 32 valid pixels per frame.
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_en = 1'b0;
   logic       hs = 1'b0, vs = 1'b0;
   logic [3:0] r = '0, g = '0, b = '0;
   logic       px_valid, frame_start, locked, err_hlen, err_hsync, err_vlen;
   logic [9:0] px_x, px_y;
   logic [3:0] px_r, px_g, px_b;
   logic [7:0] err_cnt;

   int vectors = 0;
   int miscompares = 0;

   int nvalid, n_fs, n_hlen, n_hsync, n_vlen, n_hold;
   int first_x, first_y, first_r, first_g, first_b, last_x, last_y, last_r;
   int fs_lock, fs_vlen;
   bit seen, toggle;

   vga_rx_monitor #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hs(hs), .vs(vs),
      .r(r), .g(g), .b(b),
      .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
      .px_r(px_r), .px_g(px_g), .px_b(px_b),
      .frame_start(frame_start), .locked(locked),
      .err_hlen(err_hlen), .err_hsync(err_hsync), .err_vlen(err_vlen),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [45:0] snap();
      return {px_valid, px_x, px_y, px_r, px_g, px_b, frame_start, locked,
              err_hlen, err_hsync, err_vlen, err_cnt};
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      nvalid = 0; n_fs = 0; n_hlen = 0; n_hsync = 0; n_vlen = 0; n_hold = 0;
      first_x = -1; first_y = -1; first_r = -1; first_g = -1; first_b = -1;
      last_x = -1; last_y = -1; last_r = -1; fs_lock = -1; fs_vlen = -1; seen = 0;
   endtask

   // One pixel edge at raster position (ln, col); colour encodes the position.
   task automatic pix(input int ln, input int col, input int hsw);
      logic [45:0] held;
      hs = (col < hsw); vs = (ln < 2);
      r = 4'(col); g = 4'(ln); b = 4'(col ^ ln);
      pix_en = 1'b1;
      @(posedge clk); #1;
      if (px_valid) begin
         if (!seen) begin
            seen = 1; first_x = int'(px_x); first_y = int'(px_y);
            first_r = int'(px_r); first_g = int'(px_g); first_b = int'(px_b);
         end
         last_x = int'(px_x); last_y = int'(px_y); last_r = int'(px_r);
         nvalid++;
      end
      if (err_hlen)  n_hlen++;
      if (err_hsync) n_hsync++;
      if (err_vlen)  n_vlen++;
      if (frame_start) begin
         n_fs++; fs_lock = int'(locked); fs_vlen = int'(err_vlen);
      end
      if (toggle) begin
         held = snap();
         pix_en = 1'b0; hs = ~hs; vs = ~vs; r = ~r; g = ~g; b = ~b;
         @(posedge clk); #1;
         if (snap() !== held) n_hold++;
      end
   endtask

   // Lines first_ln..last_ln; one line may be 15 long, one may have a 2-wide hsync.
   task automatic run_frame(input int first_ln, input int last_ln,
                            input int short_ln, input int narrow_ln);
      for (int ln = first_ln; ln <= last_ln; ln++) begin
         for (int col = 0; col < ((ln == short_ln) ? 15 : 16); col++) begin
            pix(ln, col, (ln == narrow_ln) ? 2 : 3);
         end
      end
   endtask

   initial begin
      toggle = 0;
      clr();

      // Reset state
      #12;
      chk("rst_px_valid", int'(px_valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Start mid-frame, then two clean frames to lock
      run_frame(5, 8, -1, -1);
      chk("mid_no_fs", n_fs, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("A_fs_cnt", n_fs, 1);
      chk("A_fs_lock", fs_lock, 0);
      chk("A_nvalid", nvalid, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("B_fs_lock", fs_lock, 1);
      chk("B_nvalid", nvalid, 32);
      chk("B_first_x", first_x, 0);
      chk("B_first_y", first_y, 0);
      chk("B_first_r", first_r, 6);
      chk("B_first_g", first_g, 4);
      chk("B_first_b", first_b, 2);
      chk("B_last_x", last_x, 7);
      chk("B_last_y", last_y, 3);
      chk("B_err_cnt", int'(err_cnt), 0);

      // Short line 5 while locked: error at the leading edge of line 6
      clr(); run_frame(0, 8, 5, -1);
      chk("D_hlen_pulses", n_hlen, 1);
      chk("D_nvalid", nvalid, 16);
      chk("D_locked", int'(locked), 0);
      chk("D_err_cnt", int'(err_cnt), 1);
      clr(); run_frame(0, 8, -1, -1);
      chk("E_fs_lock", fs_lock, 0);
      chk("E_nvalid", nvalid, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("F_fs_lock", fs_lock, 1);
      chk("F_nvalid", nvalid, 32);

      // Narrow hsync on line 2
      clr(); run_frame(0, 8, -1, 2);
      chk("G_hsync_pulses", n_hsync, 1);
      chk("G_hlen_pulses", n_hlen, 0);
      chk("G_locked", int'(locked), 0);
      chk("G_err_cnt", int'(err_cnt), 2);
      chk("G_nvalid", nvalid, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("H_fs_lock", fs_lock, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("I_fs_lock", fs_lock, 1);

      // 8-line frame: vlen error lands on the next boundary edge
      clr(); run_frame(0, 7, -1, -1);
      chk("J_nvalid", nvalid, 32);
      chk("J_vlen_pulses", n_vlen, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("K_fs_vlen", fs_vlen, 1);
      chk("K_fs_lock", fs_lock, 0);
      chk("K_vlen_pulses", n_vlen, 1);
      chk("K_err_cnt", int'(err_cnt), 3);
      clr(); run_frame(0, 8, -1, -1);
      chk("L_fs_lock", fs_lock, 0);
      chk("L_vlen_pulses", n_vlen, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("M_fs_lock", fs_lock, 1);
      chk("M_first_y", first_y, 0);

      // pix_en toggling with garbage inputs on idle cycles
      toggle = 1;
      clr(); run_frame(0, 8, -1, -1);
      toggle = 0;
      chk("N_nvalid", nvalid, 32);
      chk("N_first_x", first_x, 0);
      chk("N_last_x", last_x, 7);
      chk("N_last_y", last_y, 3);
      chk("N_last_r", last_r, 13);
      chk("N_hold_viol", n_hold, 0);
      chk("N_locked", int'(locked), 1);
      chk("N_err_cnt", int'(err_cnt), 3);

      // Asynchronous reset inside the active area
      clr(); run_frame(0, 4, -1, -1);
      for (int col = 0; col < 10; col++) pix(5, col, 3);
      chk("O_pre_valid", int'(px_valid), 1);
      chk("O_pre_x", int'(px_x), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("O_rst_valid", int'(px_valid), 0);
      chk("O_rst_locked", int'(locked), 0);
      chk("O_rst_err_cnt", int'(err_cnt), 0);
      chk("O_rst_px_x", int'(px_x), 0);
      chk("O_rst_px_r", int'(px_r), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int col = 10; col < 16; col++) pix(5, col, 3);
      run_frame(6, 8, -1, -1);
      clr(); run_frame(0, 8, -1, -1);
      chk("P_fs_lock", fs_lock, 0);
      clr(); run_frame(0, 8, -1, -1);
      chk("Q_fs_lock", fs_lock, 1);
      chk("Q_nvalid", nvalid, 32);
      chk("Q_err_cnt", int'(err_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameters: H_ACTIVE 800 (active pixels/line); H_FP 40 (front porch); H_SYNC 128 (hsync width); H_BP 88 (back porch); V_ACTIVE 600 (active lines); V_FP 1; V_SYNC 4; V_BP 23; SYNC_POL 1 (1 = sync asserted high). H_TOTAL = 1056 and V_TOTAL = 628 are derived.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel strobe; inputs are sampled only on edges where pix_en=1 ("pixel edge").
- hs, vs  in  1 each  sync inputs, polarity set by SYNC_POL.
- r, g, b  in  4 each  colour inputs.
- px_valid  out  1  registered pixel is in the active area and the block is locked.
- px_x  out  10  active column, 0..799.
- px_y  out  10  active row, 0..599.
- px_r, px_g, px_b  out  4 each  registered colour.
- frame_start  out  1  one-pixel pulse at each frame boundary.
- locked  out  1  high in the LOCKED state.
- err_hlen, err_hsync, err_vlen  out  1 each  one-pixel error pulses.
- err_cnt  out  8  saturating error count.

Function
REQ-003 SHALL leave all state and outputs unchanged on edges where pix_en=0; outputs update on the pixel edge and hold until the next one.
REQ-004 SHALL treat an hs leading edge as a pixel edge with hs asserted after the previous pixel sample was deasserted. The trailing edge is the reverse.
REQ-005 Horizontal counter h_cnt (11 bits):
- hs leading edge: h_cnt<=0; measured line length = old h_cnt+1.
- Otherwise: h_cnt increments, saturating at 2047.
REQ-006 Line-length check SHALL run only after at least one prior hs leading edge since reset: length != H_TOTAL -> err_hlen.
REQ-007 At the hs trailing edge, new h_cnt != H_SYNC -> err_hsync.
REQ-008 vs SHALL be sampled only at hs leading edges. Frame boundary = vs asserted at this hs leading edge and deasserted at the previous one.
REQ-009 Vertical counter v_cnt (10 bits), updated only at hs leading edges:
- Frame boundary: v_cnt<=0; frame_start=1; measured lines = old v_cnt+1.
- Otherwise: v_cnt increments, saturating at 1023.
REQ-010 At the second and later frame boundaries, measured lines != V_TOTAL -> err_vlen.
REQ-011 Active area: h_cnt in [216, 1015] and v_cnt in [27, 626]. px_x = h_cnt-216; px_y = v_cnt-27.
REQ-012 Pixel outputs:
- Active area and LOCKED: px_valid=1; px_r/g/b = sampled r/g/b.
- Otherwise: px_valid=0; px_x, px_y, px_r, px_g, px_b = 0.
REQ-013 FSM states SEARCH, ALIGN, LOCKED:
- SEARCH -> ALIGN at a frame boundary; error flags are suppressed in SEARCH.
- ALIGN -> SEARCH on any error.
- ALIGN -> LOCKED at the next frame boundary if no error occurred in the frame.
- LOCKED -> SEARCH on any error.
REQ-014 err_cnt SHALL increment by exactly 1 per pixel edge carrying one or more error pulses (ALIGN/LOCKED only), saturating at 255. Simultaneous errors assert all applicable flags.
REQ-015 An error and a frame boundary on the same pixel edge SHALL resolve to SEARCH, with v_cnt still reset to 0.
REQ-016 Latency SHALL be exactly one pixel edge: outputs reflect the inputs sampled at that edge.

Reset
REQ-017 rst_n=0 SHALL immediately force all outputs to 0 and clear h_cnt, v_cnt, err_cnt, the edge history and the "prior hs edge" flag, with the state set to SEARCH, regardless of pix_en or an in-progress frame.
REQ-018 After rst_n deasserts, the block SHALL resume at the first pixel edge, with no checks performed until a frame boundary is seen.

Verification
REQ-019 Clean 1056x628 stream, pix_en=1, starting mid-frame:
- locked rises at the second frame boundary.
- At line 27, h_cnt 216: first px_valid=1, px_x=0, px_y=0.
- Last valid pixel: px_x=799, px_y=599.
- 480000 valid pixels per frame; err_cnt=0.
REQ-020 Locked stream, one line 1055 pixels long -> one err_hlen pulse, locked=0, err_cnt=1; locked returns after two further frame boundaries.
REQ-021 Locked stream, one hs pulse 127 wide -> err_hsync pulse at the trailing edge, locked=0, err_cnt=1.
REQ-022 Locked stream, one frame of 627 lines -> err_vlen and frame_start on the same edge, state SEARCH, err_cnt=1.
REQ-023 Same clean stream with pix_en toggling 1/0 -> identical px_* sequence, with outputs constant on pix_en=0 cycles.
REQ-024 rst_n pulsed low mid-frame while locked -> all outputs 0 immediately, without waiting for a clock edge; relock takes two frame boundaries.
